// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and instruction classes shared by the ALU step sequencer.
package alu_seq_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
    typedef enum logic [1:0] {BINARY, UNARY, WIDE, ILLEGAL} cls_t;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps an opcode to the execute sequence class it needs.
module opcode_classifier
    import alu_seq_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opc,
    output cls_t             cls
);
    assign cls = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL} ? BINARY :
                 opc inside {OP_NEG, OP_NOT} ? UNARY :
                 opc inside {OP_MUL, OP_DIV} ? WIDE : ILLEGAL;
endmodule

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: control-step sequencer driving datapath strobes for one ALU instruction.
module alu_step_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int REG_FIELD_W = 4,
    parameter int OPC_W       = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_wait,
    input  logic [DATA_W-1:0]   ir,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [OPC_W-1:0]    alu_op,
    output logic [3:0]          step,
    output logic                busy,
    output logic                done,
    output logic                illegal
);
    localparam int LOW_W = DATA_W - OPC_W - 3 * REG_FIELD_W;

    state_t                 state;
    cls_t                   cls;
    logic [OPC_W-1:0]       opc;
    logic [REG_FIELD_W-1:0] ra, rb, rc, out_sel;
    logic                   is_bin, is_un, is_wide, out_en;
    logic                   unused_ir;

    // Shifting past the vector width yields zero, so out-of-range indices decode to no register.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_FIELD_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    assign opc       = ir[DATA_W-1 -: OPC_W];
    assign ra        = ir[DATA_W-OPC_W-1 -: REG_FIELD_W];
    assign rb        = ir[DATA_W-OPC_W-REG_FIELD_W-1 -: REG_FIELD_W];
    assign rc        = ir[DATA_W-OPC_W-2*REG_FIELD_W-1 -: REG_FIELD_W];
    assign unused_ir = ^ir[LOW_W-1:0];

    opcode_classifier #(.OPC_W(OPC_W)) u_classifier (
        .opc(opc),
        .cls(cls)
    );

    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else begin
            case (state)
                IDLE:    state <= start ? T0 : IDLE;
                T0:      state <= T1;
                T1:      state <= mem_wait ? T1 : T2;
                T2:      state <= T3;
                T3:      state <= cls == ILLEGAL ? IDLE : T4;
                T4:      state <= cls == UNARY ? IDLE : T5;
                T5:      state <= cls == WIDE ? T6 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign is_bin  = cls == BINARY;
    assign is_un   = cls == UNARY;
    assign is_wide = cls == WIDE;

    assign PCout    = state == T0;
    assign MARin    = state == T0;
    assign IncPC    = state == T0;
    assign PCin     = state == T0;
    assign Read     = state == T1;
    assign MDRin    = state == T1;
    assign MDRout   = state == T2;
    assign IRin     = state == T2;
    assign Yin      = state == T3 && (is_bin || is_wide);
    assign Zlowin   = (state == T3 && is_un) || (state == T4 && (is_bin || is_wide));
    assign Zhighin  = state == T4 && is_wide;
    assign Zlowout  = (state == T4 && is_un) || (state == T5 && (is_bin || is_wide));
    assign Zhighout = state == T6;
    assign HIin     = state == T6;
    assign LOin     = state == T5 && is_wide;
    assign done     = (state == T4 && is_un) || (state == T5 && is_bin) || state == T6;
    assign illegal  = state == T3 && cls == ILLEGAL;
    assign alu_op   = Zlowin ? opc : '0;

    // Wide ops read Ra then Rb; the others read Rb then (binary only) Rc.
    assign out_en  = (state == T3 && cls != ILLEGAL) || (state == T4 && (is_bin || is_wide));
    assign out_sel = state == T3 ? (is_wide ? ra : rb) : (is_wide ? rb : rc);
    assign reg_out = out_en ? onehot(out_sel) : '0;
    assign reg_in  = (Zlowout && !is_wide) ? onehot(ra) : '0;

    assign step = state;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb_alu_step_sequencer: directed per-cycle checks of the ALU step sequencer.
module tb_alu_step_sequencer;
    localparam logic [16:0] PCOUT = 17'h10000, MARIN = 17'h08000, INCPC = 17'h04000, PCIN = 17'h02000;
    localparam logic [16:0] READ = 17'h01000, MDRIN = 17'h00800, MDROUT = 17'h00400, IRIN = 17'h00200;
    localparam logic [16:0] YIN = 17'h00100, ZLOWIN = 17'h00080, ZHIGHIN = 17'h00040, ZLOWOUT = 17'h00020;
    localparam logic [16:0] ZHIGHOUT = 17'h00010, HIIN = 17'h00008, LOIN = 17'h00004, DONE = 17'h00002;
    localparam logic [16:0] ILL = 17'h00001;
    localparam logic [16:0] F0 = PCOUT | MARIN | INCPC | PCIN;
    localparam logic [16:0] F1 = READ | MDRIN;
    localparam logic [16:0] F2 = MDROUT | IRIN;

    logic        clock = 0, clear = 0, start = 0, mem_wait = 0;
    logic [31:0] ir = '0;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] reg_out, reg_in;
    logic [4:0]  alu_op;
    logic [3:0]  step;
    logic        busy, done, illegal;
    int          n_cmp = 0, n_err = 0;

    alu_step_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .mem_wait(mem_wait), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op), .step(step),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    wire [16:0] strb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin,
                        Zhighin, Zlowout, Zhighout, HIin, LOin, done, illegal};
    wire [58:0] obs  = {step, busy, strb, reg_out, reg_in, alu_op};

    function automatic logic [58:0] ev(input logic [3:0] s, input logic [16:0] b,
                                       input logic [15:0] ro, input logic [15:0] ri, input logic [4:0] op);
        return {s, s != 4'd0, b, ro, ri, op};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1; start = 1; tick(); tick();
        n_cmp++;
        if (obs !== 59'd0) begin n_err++; $display("FAIL reset_with_start: got %h want %h", obs, 59'd0); end
        clear = 0; start = 0; tick();
        n_cmp++;
        if (obs !== 59'd0) begin n_err++; $display("FAIL reset_idle: got %h want %h", obs, 59'd0); end
    endtask

    task automatic test_binary();
        logic [58:0] want [7];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0),
                 ev(4, YIN, 16'h0004, 0, 0), ev(5, ZLOWIN, 16'h0008, 0, 5'b00101),
                 ev(6, ZLOWOUT | DONE, 0, 16'h0002, 0), ev(0, 0, 0, 0, 0)};
        ir = 32'h28918000; start = 1; tick(); start = 0;
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL binary_and cyc%0d: got %h want %h", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_unary();
        logic [58:0] want [6];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0),
                 ev(4, ZLOWIN, 16'h0080, 0, 5'b10010), ev(5, ZLOWOUT | DONE, 0, 16'h0040, 0),
                 ev(0, 0, 0, 0, 0)};
        ir = 32'h93380000; start = 1; tick(); start = 0;
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL unary_not cyc%0d: got %h want %h", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_wide();
        logic [58:0] want [8];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0),
                 ev(4, YIN, 16'h0008, 0, 0), ev(5, ZLOWIN | ZHIGHIN, 16'h0010, 0, 5'b01111),
                 ev(6, ZLOWOUT | LOIN, 0, 0, 0), ev(7, ZHIGHOUT | HIIN | DONE, 0, 0, 0),
                 ev(0, 0, 0, 0, 0)};
        ir = 32'h79A00000; start = 1; tick(); start = 0;
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL wide_mul cyc%0d: got %h want %h", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [58:0] want [10];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(2, F1, 0, 0, 0),
                 ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0), ev(4, YIN, 16'h0004, 0, 0),
                 ev(5, ZLOWIN, 16'h0008, 0, 5'b00101), ev(6, ZLOWOUT | DONE, 0, 16'h0002, 0),
                 ev(0, 0, 0, 0, 0)};
        ir = 32'h28918000; start = 1; tick(); start = 0;
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL stall cyc%0d: got %h want %h", i, obs, want[i]); end
            mem_wait = i >= 1 && i <= 3;
            tick();
        end
        mem_wait = 0;
    endtask

    task automatic test_illegal();
        logic [58:0] want [6];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0),
                 ev(4, ILL, 0, 0, 0), ev(0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0)};
        ir = 32'hF8918000; start = 1; tick(); start = 0;
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL illegal cyc%0d: got %h want %h", i, obs, want[i]); end
            tick();
        end
    endtask

    task automatic test_clear();
        int cyc;
        ir = 32'h28918000; start = 1; tick(); start = 0;
        repeat (4) tick();
        n_cmp++;
        if (obs !== ev(5, ZLOWIN, 16'h0008, 0, 5'b00101)) begin
            n_err++; $display("FAIL clear_pre_t4: got %h want %h", obs, ev(5, ZLOWIN, 16'h0008, 0, 5'b00101));
        end
        clear = 1; tick(); clear = 0;
        n_cmp++;
        if (obs !== 59'd0) begin n_err++; $display("FAIL clear_mid_exec: got %h want %h", obs, 59'd0); end
        tick();
        n_cmp++;
        if (obs !== 59'd0) begin n_err++; $display("FAIL clear_no_done: got %h want %h", obs, 59'd0); end
        ir = 32'h93380000; start = 1; tick(); start = 0;
        n_cmp++;
        if (obs !== ev(1, F0, 0, 0, 0)) begin n_err++; $display("FAIL clear_restart: got %h want %h", obs, ev(1, F0, 0, 0, 0)); end
        cyc = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL clear_restart_latency: got %0d want %0d", cyc, 4); end
        n_cmp++;
        if (reg_in !== 16'h0040) begin n_err++; $display("FAIL clear_restart_regin: got %h want %h", reg_in, 16'h0040); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [58:0] want [8];
        want = '{ev(1, F0, 0, 0, 0), ev(2, F1, 0, 0, 0), ev(3, F2, 0, 0, 0),
                 ev(4, YIN, 16'h0200, 0, 0), ev(5, ZLOWIN, 16'h8000, 0, 5'b00100),
                 ev(6, ZLOWOUT | DONE, 0, 16'h0020, 0), ev(0, 0, 0, 0, 0), ev(1, F0, 0, 0, 0)};
        ir = 32'h22CF8000; start = 1; tick();
        foreach (want[i]) begin
            n_cmp++;
            if (obs !== want[i]) begin n_err++; $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, want[i]); end
            tick();
        end
        start = 0; clear = 1; tick(); clear = 0;
    endtask

    initial begin
        test_reset();
        test_binary();
        test_unary();
        test_wide();
        test_stall();
        test_illegal();
        test_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
